// File: rtl/op_slot_sequencer.sv
// ============================================================================
// Module   : op_slot_sequencer
// Brief    : Time-division scheduler that issues every (bank, op) slot into the
//            shared operator pipeline once per sample strobe and carries a
//            matching {valid, bank, op} tag pipeline alongside it.
//            Optional macro OP_SLOT_SEQ_OVERRUN_CNT_EN adds the overrun_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_slot_sequencer #(
    parameter int NUM_BANKS        = 2,
    parameter int NUM_OPS_PER_BANK = 18,
    parameter int PIPELINE_DEPTH   = 7,
    parameter int ISSUE_INTERVAL   = 1,
    localparam int BANK_W          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_clk_en,
    input  logic              overrun_clr,
    output logic              issue,
    output logic [BANK_W-1:0] issue_bank,
    output logic [4:0]        issue_op,
    output logic              out_valid,
    output logic [BANK_W-1:0] out_bank,
    output logic [4:0]        out_op,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
`ifdef OP_SLOT_SEQ_OVERRUN_CNT_EN
    ,
    output logic [7:0]        overrun_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int TAG_W = 1 + BANK_W + 5;
    localparam int GAP_W = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((ISSUE_INTERVAL > 1) ? ISSUE_INTERVAL - 2 : 0);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [4:0]        LAST_OP   = 5'(NUM_OPS_PER_BANK - 1);

    logic [1:0]        state;
    logic [BANK_W-1:0] bank_cnt;
    logic [4:0]        op_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TAG_W-1:0]  tag_pipe [PIPELINE_DEPTH];

    logic              last_slot;
    logic              strobe_drop;
    logic [BANK_W-1:0] next_bank;
    logic [4:0]        next_op;

    assign last_slot   = (bank_cnt == LAST_BANK) && (op_cnt == LAST_OP);
    assign strobe_drop = sample_clk_en && (state != S_IDLE);

    always_comb begin
        next_bank = bank_cnt;
        next_op   = op_cnt + 5'd1;
        if (op_cnt == LAST_OP) begin
            next_op   = 5'd0;
            next_bank = bank_cnt + BANK_W'(1);
        end
    end

    // Slot counters only advance when the next issue starts, so they hold through gaps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            bank_cnt <= '0;
            op_cnt   <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sample_clk_en) begin
                        state    <= S_ISSUE;
                        bank_cnt <= '0;
                        op_cnt   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (last_slot) begin
                        state <= S_DRAIN;
                    end else if (ISSUE_INTERVAL == 1) begin
                        bank_cnt <= next_bank;
                        op_cnt   <= next_op;
                    end else begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state    <= S_ISSUE;
                        bank_cnt <= next_bank;
                        op_cnt   <= next_op;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    if (frame_done) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Idle tag slots carry zeros so out_bank/out_op read 0 whenever out_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPELINE_DEPTH; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= issue ? {1'b1, bank_cnt, op_cnt} : '0;
            for (int i = 1; i < PIPELINE_DEPTH; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign issue      = (state == S_ISSUE);
    assign issue_bank = bank_cnt;
    assign issue_op   = op_cnt;
    assign {out_valid, out_bank, out_op} = tag_pipe[PIPELINE_DEPTH-1];
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DRAIN) && out_valid &&
                        (out_bank == LAST_BANK) && (out_op == LAST_OP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (strobe_drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef OP_SLOT_SEQ_OVERRUN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_cnt <= 8'd0;
        end else if (strobe_drop && overrun_clr) begin
            overrun_cnt <= 8'd1;
        end else if (strobe_drop) begin
            if (overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end else if (overrun_clr) begin
            overrun_cnt <= 8'd0;
        end
    end
`else
    // Drop counter not built; only the sticky overrun flag records drops.
`endif

endmodule

`default_nettype wire

// File: tb/tb_op_slot_sequencer.sv
// ============================================================================
// Module   : tb_op_slot_sequencer
// Brief    : Randomized + directed bench for op_slot_sequencer, two parameter
//            sets, checked against a per-frame timing model.
//            Honors OP_SLOT_SEQ_OVERRUN_CNT_EN for the overrun_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_op_slot_sequencer;

    localparam int NB = 2;
    localparam int P_N  [2] = '{18, 4};
    localparam int P_D  [2] = '{7, 2};
    localparam int P_II [2] = '{1, 3};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic strobe = 1'b0;
    logic clr = 1'b0;

    logic       issue_s   [2];
    logic [0:0] issue_b   [2];
    logic [4:0] issue_o   [2];
    logic       out_v     [2];
    logic [0:0] out_b     [2];
    logic [4:0] out_o     [2];
    logic       busy_s    [2];
    logic       done_s    [2];
    logic       ovr_s     [2];
    logic [7:0] ovr_cnt_s [2];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // model state per DUT
    bit act [2];
    int fs  [2];
    bit ov  [2];
    int cnt [2];

    always #5 clk = ~clk;

    op_slot_sequencer #(
        .NUM_BANKS(NB), .NUM_OPS_PER_BANK(18), .PIPELINE_DEPTH(7), .ISSUE_INTERVAL(1)
    ) u_dut0 (
        .clk(clk), .reset(reset), .sample_clk_en(strobe), .overrun_clr(clr),
        .issue(issue_s[0]), .issue_bank(issue_b[0]), .issue_op(issue_o[0]),
        .out_valid(out_v[0]), .out_bank(out_b[0]), .out_op(out_o[0]),
        .busy(busy_s[0]), .frame_done(done_s[0]), .overrun(ovr_s[0])
`ifdef OP_SLOT_SEQ_OVERRUN_CNT_EN
        , .overrun_cnt(ovr_cnt_s[0])
`endif
    );

    op_slot_sequencer #(
        .NUM_BANKS(NB), .NUM_OPS_PER_BANK(4), .PIPELINE_DEPTH(2), .ISSUE_INTERVAL(3)
    ) u_dut1 (
        .clk(clk), .reset(reset), .sample_clk_en(strobe), .overrun_clr(clr),
        .issue(issue_s[1]), .issue_bank(issue_b[1]), .issue_op(issue_o[1]),
        .out_valid(out_v[1]), .out_bank(out_b[1]), .out_op(out_o[1]),
        .busy(busy_s[1]), .frame_done(done_s[1]), .overrun(ovr_s[1])
`ifdef OP_SLOT_SEQ_OVERRUN_CNT_EN
        , .overrun_cnt(ovr_cnt_s[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Cycle (relative to frame start) of the last slot reaching the final stage.
    function automatic int last_out(input int i);
        return 1 + (NB * P_N[i] - 1) * P_II[i] + P_D[i];
    endfunction

    function automatic bit model_busy(input int i, input int c);
        return act[i] && (c >= fs[i] + 1) && (c <= fs[i] + last_out(i));
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int off;
            int off2;
            int span;
            bit e_iss;
            bit e_out;
            span  = (NB * P_N[i] - 1) * P_II[i];
            off   = cyc - fs[i] - 1;
            off2  = off - P_D[i];
            e_iss = act[i] && off >= 0 && off <= span && (off % P_II[i]) == 0;
            e_out = act[i] && off2 >= 0 && off2 <= span && (off2 % P_II[i]) == 0;
            check($sformatf("issue%0d", i), 32'(issue_s[i]), 32'(e_iss));
            if (e_iss) begin
                check($sformatf("issue_bank%0d", i), 32'(issue_b[i]), 32'((off / P_II[i]) / P_N[i]));
                check($sformatf("issue_op%0d", i),   32'(issue_o[i]), 32'((off / P_II[i]) % P_N[i]));
            end
            check($sformatf("out_valid%0d", i), 32'(out_v[i]), 32'(e_out));
            if (e_out) begin
                check($sformatf("out_bank%0d", i), 32'(out_b[i]), 32'((off2 / P_II[i]) / P_N[i]));
                check($sformatf("out_op%0d", i),   32'(out_o[i]), 32'((off2 / P_II[i]) % P_N[i]));
            end
            check($sformatf("busy%0d", i), 32'(busy_s[i]), 32'(model_busy(i, cyc)));
            check($sformatf("frame_done%0d", i), 32'(done_s[i]),
                  32'(act[i] && cyc == fs[i] + last_out(i)));
            check($sformatf("overrun%0d", i), 32'(ovr_s[i]), 32'(ov[i]));
`ifdef OP_SLOT_SEQ_OVERRUN_CNT_EN
            check($sformatf("overrun_cnt%0d", i), 32'(ovr_cnt_s[i]), 32'(cnt[i]));
`endif
        end
    endtask

    task automatic update(input bit s, input bit c, input bit r);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                act[i] = 1'b0;
                ov[i]  = 1'b0;
                cnt[i] = 0;
            end else begin
                bit b;
                bit drop;
                b    = model_busy(i, cyc);
                drop = s && b;
                if (s && !b) begin
                    act[i] = 1'b1;
                    fs[i]  = cyc;
                end
                if (drop)   ov[i] = 1'b1;
                else if (c) ov[i] = 1'b0;
                if (drop && c)  cnt[i] = 1;
                else if (drop)  cnt[i] = (cnt[i] < 255) ? cnt[i] + 1 : 255;
                else if (c)     cnt[i] = 0;
            end
        end
    endtask

    // One cycle: check the current outputs, then drive the inputs sampled at the next edge.
    task automatic step(input bit s, input bit c, input bit r);
        @(negedge clk);
        check_all();
        strobe = s;
        clr    = c;
        reset  = r;
        update(s, c, r);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; fs[i] = 0; ov[i] = 1'b0; cnt[i] = 0;
        end
        repeat (3) step(1'b0, 1'b0, 1'b1);
        idle(3);

        // single default frame
        step(1'b1, 1'b0, 1'b0);
        idle(50);

        // strobes at t+10 and t+43 during a frame
        step(1'b1, 1'b0, 1'b0);
        idle(9);
        step(1'b1, 1'b0, 1'b0);
        idle(32);
        step(1'b1, 1'b0, 1'b0);
        idle(50);

        // drop and clear in the same cycle, then clear alone
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b0);
        idle(50);

        // reset mid-frame, then a full frame from (0,0)
        step(1'b1, 1'b0, 1'b0);
        idle(19);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(20);
        step(1'b1, 1'b0, 1'b0);
        idle(50);

        // back-to-back: strobe in the cycle right after frame_done
        step(1'b1, 1'b0, 1'b0);
        idle(43);
        step(1'b1, 1'b0, 1'b0);
        idle(50);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 699) == 0);
        end
        idle(50);

        // continuous strobes drive the drop count to saturation
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 400; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/op_slot_sequencer.md
Name: op_slot_sequencer

Overview:
- Time-division scheduler for the shared operator datapath pipeline.
- On each sample-rate strobe it issues every operator slot (bank 0 ops 0..N-1, then bank 1 ops 0..N-1) into stage 1 of the pipeline, one slot per issue.
- It carries a matching valid/bank/op tag shift register alongside the datapath, so downstream stages see which slot exits the last stage.
- It signals frame completion, and flags strobes that arrive before the previous frame has drained.

Parameters:
- NUM_BANKS, 2, number of operator banks; BANK_W = max(1, $clog2(NUM_BANKS)).
- NUM_OPS_PER_BANK, 18, operators per bank; must be 1..32.
- PIPELINE_DEPTH, 7, cycles from issue to the datapath's final stage; must be >= 1.
- ISSUE_INTERVAL, 1, cycles between consecutive issues; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_clk_en  in  1  one-cycle strobe that starts a frame.
- overrun_clr  in  1  clears the overrun flag.
- issue  out  1  one-cycle pulse: present the slot to pipeline stage 1.
- issue_bank  out  BANK_W  bank of the slot being issued.
- issue_op  out  5  operator index of the slot being issued.
- out_valid  out  1  slot is at the pipeline's final stage.
- out_bank  out  BANK_W  bank tag at the final stage.
- out_op  out  5  op tag at the final stage.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse on the final out_valid of a frame.
- overrun  out  1  sticky flag: a strobe was dropped.

Behaviour:
- Reset state: every output 0, tag pipeline cleared, state IDLE. Reset asserted mid-frame aborts the frame; no out_valid is produced for in-flight slots after reset is released.
- States:
  - IDLE: sample_clk_en=1 goes to ISSUE; busy goes high the next cycle.
  - ISSUE: asserts issue with the current (bank, op) for exactly one cycle. If this was the last slot, go to DRAIN. Else, if ISSUE_INTERVAL=1, stay in ISSUE with the slot advanced; otherwise go to GAP.
  - GAP: waits ISSUE_INTERVAL-1 cycles, then returns to ISSUE.
  - DRAIN: waits until the last slot's tag reaches the final stage, then returns to IDLE. frame_done is asserted in that same final-stage cycle.
- Slot order:
  - op increments 0..NUM_OPS_PER_BANK-1 within a bank.
  - On wrap, op returns to 0 and bank increments.
  - Last slot = (NUM_BANKS-1, NUM_OPS_PER_BANK-1).
  - Counters reset to (0,0) at frame start.
- issue_bank/issue_op hold their value while issue=0 and are don't-care to consumers.
- Timing: a strobe accepted in cycle t gives:
  - issue k (k = 0..S-1, S = NUM_BANKS*NUM_OPS_PER_BANK) in cycle t+1+k*ISSUE_INTERVAL.
  - out_valid for slot k exactly PIPELINE_DEPTH cycles later, with tags identical to those issued.
  - Defaults: issues in t+1..t+36; out_valid in t+8..t+43; frame_done in t+43.
- Tag pipeline: a PIPELINE_DEPTH-stage shift register of {valid, bank, op}, shifted every cycle. There is no stall. out_* are taken from the last stage.
- busy is high from t+1 through the frame_done cycle inclusive, then 0 the next cycle.
- Overrun:
  - sample_clk_en while busy=1 (including the frame_done cycle) is ignored and sets overrun the next cycle.
  - overrun_clr clears it.
  - Set and clear in the same cycle: set wins.
  - The running frame is unaffected.
- The strobe that sets overrun is dropped, never queued. The first strobe seen in IDLE starts the next frame.

Optional Feature:
- Macro: OP_SLOT_SEQ_OVERRUN_CNT_EN.
- Defined: adds output port overrun_cnt (out, 8 bits).
  - Resets to 0.
  - Increments by 1 on each dropped strobe and saturates at 255.
  - Cleared by overrun_clr; on a same-cycle drop and clear the result is 1.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then a single sample_clk_en at cycle t with defaults -> 36 issue pulses in t+1..t+36 with (bank,op) = (0,0)..(0,17),(1,0)..(1,17). out_valid in t+8..t+43 with matching tags. frame_done only at t+43. busy high t+1..t+43.
- ISSUE_INTERVAL=3, NUM_OPS_PER_BANK=4, PIPELINE_DEPTH=2 -> issues at t+1, t+4, ..., t+22. frame_done at t+24. No issue in gap cycles.
- Strobe at t+10 and at t+43 during a default frame -> both ignored, overrun=1 from t+11, and the frame completes unchanged. overrun_clr and a strobe drop in the same cycle -> overrun stays 1. overrun_clr alone -> 0 the next cycle.
- Assert reset at t+20 mid-frame and release at t+22 -> all outputs 0, no out_valid afterwards. A new strobe then runs a full frame starting from (0,0).
- Back-to-back: a strobe in the cycle after frame_done (busy=0) -> accepted with no overrun, and the next frame's first issue arrives one cycle later.
- With OP_SLOT_SEQ_OVERRUN_CNT_EN: 300 dropped strobes -> overrun_cnt=255. overrun_clr -> 0.
